alu_operand_loader: RTL
=======================

// Module: alu_operand_loader
// PURPOSE
//  Board-input front end for the ALU FPGA build: turns raw push-buttons and slide
//  switches into registered operands and an opcode for the alu_if (portA, portB, aluOp).
//  Debounces the keys and sequences entry A -> B -> op through an FSM.
//  Asserts op_valid once a complete operation is loaded. Sits between board pins and alu.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  consecutive stable cycles before a key level is accepted (10 ms @ 50 MHz)
//  SW_W             16      switch bits used as operand data
//  DATA_W           32      operand width (alu_if port width)
// PORTS
//  CLK       in   1       system clock
//  nRST      in   1       asynchronous reset, active-low
//  key_n     in   4       raw push-buttons, active-low, asynchronous; [0]=enter, [1]=cancel, [3:2] unused
//  sw        in   18      raw switches; [15:0] data, [16] sign-fill, [3:0] opcode in S_OP, [17] unused
//  portA     out  DATA_W  operand A to alu_if
//  portB     out  DATA_W  operand B to alu_if
//  aluOp     out  aluop_t opcode to alu_if
//  op_valid  out  1       high while a complete A/B/op set is held
//  state     out  2       current FSM state encoding, for LED display
// BEHAVIOUR
//  Reset (nRST=0, async): portA=portB=0, aluOp=0, op_valid=0, state=S_A.
//    Debounce counters=0; debounced key levels=released (1). Synchronizer flops=1.
//  Input path, per key: 2-flop synchronizer, then debounce.
//    Debounced level changes only after the synced level differs from it for DEBOUNCE_CYCLES consecutive cycles.
//    Any return to the current debounced level clears the counter.
//  press pulse: 1 cycle, on debounced 1->0 transition. A held key yields exactly one pulse; release yields none.
//  Key-to-pulse latency: 2 sync + DEBOUNCE_CYCLES + 1 cycles after a clean edge.
//  Operand format: {{(DATA_W-SW_W){sw[16]}}, sw[15:0]}. sw is sampled through a 2-flop synchronizer.
//  FSM (registered, all updates on the CLK edge after the pulse):
//    S_A   enter: portA<=operand; ->S_B
//    S_B   enter: portB<=operand; ->S_OP
//    S_OP  enter: aluOp<=aluop_t'(sw[3:0]); op_valid<=1; ->S_DONE
//    S_DONE  enter: op_valid<=0; ->S_A (portA, portB and aluOp hold until overwritten)
//    any   cancel: portA=portB=0, aluOp=0, op_valid=0; ->S_A
//  Precedence: cancel and enter pulses in the same cycle -> cancel wins; enter is dropped.
//  Switch changes have no effect except on the enter pulse. Outputs are stable between pulses.
//  Reset mid-debounce or mid-sequence -> full reset state. A key still held after reset
//    deasserts produces no pulse until it is released and pressed again.
//  Unused keys [3:2] are synchronized only; they have no function.
//  Counter width: $clog2(DEBOUNCE_CYCLES+1). Counter saturates and never wraps.
// STRUCTURE
//  cpu_types_pkg: reuse aluop_t; add loader_state_t enum {S_A=2'd0, S_B=2'd1, S_OP=2'd2, S_DONE=2'd3}.
//  Sub-module key_debounce (params DEBOUNCE_CYCLES): ports CLK, nRST, key_n, press.
//    Contains the synchronizer, counter and edge detect; instantiated once per key.
//  Top level holds the sw synchronizer, the operand formatter and the FSM.
// TESTING  (bench uses DEBOUNCE_CYCLES=4)
//  Full sequence:
//    sw=0x0_1234, press enter -> portA=0x00001234
//    sw=0x1_0002, press enter -> portB=0xFFFF0002
//    sw[3:0]=ADD, press enter -> aluOp=ADD, op_valid=1, state=3
//  Bounce: key_n toggles every 2 cycles for 20 cycles, then holds low -> exactly one
//    press pulse, 4+3 cycles after the last toggle.
//  Hold: enter held low 100 cycles -> one state advance only; release causes no change.
//  Simultaneous: enter and cancel debounced in the same cycle from S_OP -> state=S_A,
//    op_valid=0, portA=portB=0.
//  Reset mid-op: nRST pulsed low in S_B with portA=0x1234 -> portA=0 and state=S_A immediately (async).
//    Held enter gives no pulse until it is re-pressed.
//  Wrap-back: from S_DONE press enter -> op_valid=0, state=S_A, portA/portB/aluOp unchanged.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared ALU opcode and operand-loader state types
package cpu_types_pkg;

    // ALU opcode presented on alu_if.aluOp; encodings follow the 4-bit switch field.
    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    // Operand entry sequence; encoding is shown on the board LEDs.
    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_OP   = 2'd2,
        S_DONE = 2'd3
    } loader_state_t;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchronizer, debouncer and press detector for one push-button
//
// Ports:
//   CLK    in  system clock
//   nRST   in  asynchronous reset, active-low
//   key_n  in  raw push-button, active-low, asynchronous
//   press  out one-cycle pulse on an accepted press (debounced 1->0)
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLK,
    input  logic nRST,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic [1:0]       primed_q, primed_d;
    logic             armed_q, armed_d;
    logic             deb_q, deb_d;
    logic             deb_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        if (sync2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q >= CNT_LAST) begin
            // Nth consecutive differing cycle: accept the new level.
            deb_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // The synchronizer resets to "released", so its output is not trustworthy
    // until two edges after reset. Only a genuinely observed released level
    // arms the detector; a key held through reset therefore never pulses.
    always_comb begin
        primed_d = {primed_q[0], 1'b1};
        armed_d  = armed_q | (primed_q[1] & sync2_q);
        press_d  = armed_q & deb_prev_q & ~deb_q;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            primed_q   <= 2'b00;
            armed_q    <= 1'b0;
            deb_q      <= 1'b1;
            deb_prev_q <= 1'b1;
            cnt_q      <= '0;
            press_q    <= 1'b0;
        end else begin
            sync1_q    <= key_n;
            sync2_q    <= sync1_q;
            primed_q   <= primed_d;
            armed_q    <= armed_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            cnt_q      <= cnt_d;
            press_q    <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/alu_operand_loader.sv
// rtl/alu_operand_loader.sv - board-key front end loading ALU operands and opcode
//
// Ports:
//   CLK       in  system clock
//   nRST      in  asynchronous reset, active-low
//   key_n     in  raw push-buttons, active-low; [0]=enter, [1]=cancel, [3:2] unused
//   sw        in  raw switches; [15:0] data, [16] sign-fill, [3:0] opcode, [17] unused
//   portA     out operand A
//   portB     out operand B
//   aluOp     out opcode
//   op_valid  out high while a complete A/B/op set is held
//   state     out FSM state for LED display
module alu_operand_loader
    import cpu_types_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SW_W            = 16,
    parameter int DATA_W          = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [3:0]        key_n,
    input  logic [17:0]       sw,
    output logic [DATA_W-1:0] portA,
    output logic [DATA_W-1:0] portB,
    output aluop_t            aluOp,
    output logic              op_valid,
    output logic [1:0]        state
);

    logic [17:0]       sw_s1_q, sw_s2_q;
    logic [1:0]        spare_s1_q, spare_s2_q;
    logic              enter_press, cancel_press;
    logic [DATA_W-1:0] operand;

    loader_state_t     state_q, state_d;
    logic [DATA_W-1:0] port_a_q, port_a_d;
    logic [DATA_W-1:0] port_b_q, port_b_d;
    aluop_t            alu_op_q, alu_op_d;
    logic              op_valid_q, op_valid_d;

    logic              unused_ok;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_enter (
        .CLK   (CLK),
        .nRST  (nRST),
        .key_n (key_n[0]),
        .press (enter_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_cancel (
        .CLK   (CLK),
        .nRST  (nRST),
        .key_n (key_n[1]),
        .press (cancel_press)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
            spare_s1_q <= 2'b11;
            spare_s2_q <= 2'b11;
        end else begin
            sw_s1_q    <= sw;
            sw_s2_q    <= sw_s1_q;
            spare_s1_q <= key_n[3:2];
            spare_s2_q <= spare_s1_q;
        end
    end

    // Switch data zero- or one-filled to the ALU width by sw[16].
    assign operand = {{(DATA_W-SW_W){sw_s2_q[16]}}, sw_s2_q[SW_W-1:0]};

    always_comb begin
        state_d    = state_q;
        port_a_d   = port_a_q;
        port_b_d   = port_b_q;
        alu_op_d   = alu_op_q;
        op_valid_d = op_valid_q;
        if (cancel_press) begin
            // Cancel wins over a coincident enter.
            state_d    = S_A;
            port_a_d   = '0;
            port_b_d   = '0;
            alu_op_d   = aluop_t'(4'd0);
            op_valid_d = 1'b0;
        end else if (enter_press) begin
            case (state_q)
                S_A: begin
                    port_a_d = operand;
                    state_d  = S_B;
                end
                S_B: begin
                    port_b_d = operand;
                    state_d  = S_OP;
                end
                S_OP: begin
                    alu_op_d   = aluop_t'(sw_s2_q[3:0]);
                    op_valid_d = 1'b1;
                    state_d    = S_DONE;
                end
                S_DONE: begin
                    op_valid_d = 1'b0;
                    state_d    = S_A;
                end
                default: state_d = S_A;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= S_A;
            port_a_q   <= '0;
            port_b_q   <= '0;
            alu_op_q   <= aluop_t'(4'd0);
            op_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            port_a_q   <= port_a_d;
            port_b_q   <= port_b_d;
            alu_op_q   <= alu_op_d;
            op_valid_q <= op_valid_d;
        end
    end

    assign portA    = port_a_q;
    assign portB    = port_b_q;
    assign aluOp    = alu_op_q;
    assign op_valid = op_valid_q;
    assign state    = state_q;

    // Spare keys and sw[17] are synchronized but have no function.
    assign unused_ok = ^{sw_s2_q[17], spare_s2_q};

endmodule
